sdram_resp: RTL and testbench

SDRAM_RESP -- requirements
Module: sdram_resp

---
 rtl/sdram_resp.sv | 234 +++++++++++++++++++++++
 tb/tb_sdram_resp.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_resp.sv
// SDRAM device responder: decodes the command bus, keeps per-bank row state,
// stores write data, returns read beats after the CAS latency and flags protocol errors.
module sdram_resp #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4,
    parameter int T_RCD    = 2
) (
    input  logic        tb_clk,
    input  logic        tb_rst,
    input  logic        Cke,
    input  logic        Cs_n,
    input  logic        Ras_n,
    input  logic        Cas_n,
    input  logic        We_n,
    input  logic [1:0]  Ba,
    input  logic [10:0] Addr,
    input  logic [3:0]  Dqm,
    input  logic [31:0] Dq_in,
    output logic [31:0] Dq_out,
    output logic [31:0] Dq_oe,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [1:0]  cl
);

    localparam int AGE_W = (T_RCD < 1) ? 1 : $clog2(T_RCD + 1);
    localparam int IDX_W = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic { BANK_IDLE, BANK_ACTIVE } bank_state_t;
    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACTIVE, CMD_READ, CMD_WRITE, CMD_PRECHARGE, CMD_REFRESH, CMD_MODE
    } cmd_t;

    cmd_t                cmd;
    bank_state_t         bank_q [4];
    bank_state_t         bank_d [4];
    logic [ROW_BITS-1:0] row_q [4];
    logic [AGE_W-1:0]    age_q [4];
    logic [31:0]         mem [DEPTH];
    logic [IDX_W-1:0]    idx;
    logic                any_active;
    logic                access_ok;
    logic                mode_ok;
    logic                err_det;
    logic [2:0]          err_det_code;
    logic                read_go;
    logic                write_go;
    logic [2:0]          pv;
    logic [31:0]         pdata [3];
    logic [3:0]          pmask [3];
    logic [31:0]         beat_oe;
    logic                out_valid;
    logic                unused_addr;

    assign unused_addr = ^Addr;

    always_comb begin
        cmd = CMD_NOP;
        if (Cke && !Cs_n) begin
            case ({Ras_n, Cas_n, We_n})
                3'b011:  cmd = CMD_ACTIVE;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRECHARGE;
                3'b001:  cmd = CMD_REFRESH;
                3'b000:  cmd = CMD_MODE;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // The age register counts whole cycles since ACTIVE; the edge being judged adds one.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            bank_d[b] = bank_q[b];
        end
        any_active   = 1'b0;
        access_ok    = 1'b0;
        mode_ok      = 1'b0;
        err_det      = 1'b0;
        err_det_code = 3'd0;
        for (int b = 0; b < 4; b++) begin
            any_active = any_active | (bank_q[b] == BANK_ACTIVE);
        end
        case (cmd)
            CMD_ACTIVE: begin
                if (bank_q[Ba] == BANK_IDLE) begin
                    bank_d[Ba] = BANK_ACTIVE;
                end else begin
                    err_det      = 1'b1;
                    err_det_code = 3'd2;
                end
            end
            CMD_PRECHARGE: begin
                if (Addr[10]) begin
                    for (int b = 0; b < 4; b++) begin
                        bank_d[b] = BANK_IDLE;
                    end
                end else begin
                    bank_d[Ba] = BANK_IDLE;
                end
            end
            CMD_REFRESH: begin
                if (any_active) begin
                    err_det      = 1'b1;
                    err_det_code = 3'd6;
                end
            end
            CMD_MODE: begin
                if (any_active) begin
                    err_det      = 1'b1;
                    err_det_code = 3'd6;
                end else if (Addr[6:5] == 2'b01 && Addr[2:0] == 3'b000) begin
                    mode_ok = 1'b1;
                end else begin
                    err_det      = 1'b1;
                    err_det_code = 3'd5;
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (cl == 2'd0) begin
                    err_det      = 1'b1;
                    err_det_code = 3'd4;
                end else if (bank_q[Ba] == BANK_IDLE) begin
                    err_det      = 1'b1;
                    err_det_code = 3'd1;
                end else if ((int'(age_q[Ba]) + 1) < T_RCD) begin
                    err_det      = 1'b1;
                    err_det_code = 3'd3;
                end else begin
                    access_ok = 1'b1;
                    if (cmd == CMD_WRITE && out_valid) begin
                        err_det      = 1'b1;
                        err_det_code = 3'd7;
                    end
                end
            end
            default: ;
        endcase
    end

    assign idx      = {Ba, row_q[Ba], Addr[COL_BITS-1:0]};
    assign read_go  = access_ok && (cmd == CMD_READ);
    assign write_go = access_ok && (cmd == CMD_WRITE);

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            for (int b = 0; b < 4; b++) begin
                bank_q[b] <= BANK_IDLE;
                row_q[b]  <= '0;
                age_q[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                bank_q[b] <= bank_d[b];
                if (cmd == CMD_ACTIVE && Ba == 2'(b) && bank_q[b] == BANK_IDLE) begin
                    row_q[b] <= Addr[ROW_BITS-1:0];
                    age_q[b] <= '0;
                end else if (age_q[b] < AGE_W'(T_RCD)) begin
                    age_q[b] <= age_q[b] + AGE_W'(1);
                end
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge tb_clk) begin
        if (write_go) begin
            for (int i = 0; i < 4; i++) begin
                if (!Dqm[i]) begin
                    mem[idx][8*i +: 8] <= Dq_in[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        beat_oe = '0;
        for (int i = 0; i < 4; i++) begin
            beat_oe[8*i +: 8] = {8{~pmask[0][i]}};
        end
    end

    // Stage 0 feeds the output register next edge; CL2 enters at stage 1, CL3 at stage 2.
    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            pv        <= '0;
            for (int i = 0; i < 3; i++) begin
                pdata[i] <= '0;
                pmask[i] <= '0;
            end
            out_valid <= 1'b0;
            Dq_out    <= '0;
            Dq_oe     <= '0;
        end else begin
            pv[0]    <= pv[1];
            pdata[0] <= pdata[1];
            pmask[0] <= pmask[1];
            if (read_go && cl == 2'd2) begin
                pv[1]    <= 1'b1;
                pdata[1] <= mem[idx];
                pmask[1] <= Dqm;
            end else begin
                pv[1]    <= pv[2];
                pdata[1] <= pdata[2];
                pmask[1] <= pmask[2];
            end
            pv[2]     <= read_go && (cl == 2'd3);
            pdata[2]  <= mem[idx];
            pmask[2]  <= Dqm;
            out_valid <= pv[0];
            Dq_out    <= pv[0] ? pdata[0] : '0;
            Dq_oe     <= pv[0] ? beat_oe : '0;
        end
    end

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            err      <= 1'b0;
            err_code <= 3'd0;
            cl       <= 2'd0;
        end else begin
            if (err_det && !err) begin
                err      <= 1'b1;
                err_code <= err_det_code;
            end
            if (mode_ok) begin
                cl <= {1'b1, Addr[4]};
            end
        end
    end

endmodule

// File: tb/tb_sdram_resp.sv
// Self-checking bench for sdram_resp: directed scenarios with literal expectations
// plus randomized command streams compared every cycle against a behavioural model.
module tb_sdram_resp;

    localparam int T_RCD = 2;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_MRS = 3'b000;
    localparam logic [2:0] C_NOP = 3'b111;

    logic        tb_clk = 1'b0;
    logic        tb_rst = 1'b1;
    logic        Cke, Cs_n, Ras_n, Cas_n, We_n;
    logic [1:0]  Ba;
    logic [10:0] Addr;
    logic [3:0]  Dqm;
    logic [31:0] Dq_in;
    logic [31:0] Dq_out;
    logic [31:0] Dq_oe;
    logic        err;
    logic [2:0]  err_code;
    logic [1:0]  cl;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          cyc = 0;
    bit          m_open [4];
    int          m_row [4];
    int          m_act [4];
    int          m_cl;
    bit          m_err;
    int          m_code;
    logic [7:0]  m_mem [int];
    bit          exp_valid [int];
    logic [31:0] exp_data [int];
    logic [31:0] exp_known [int];
    logic [31:0] exp_oe [int];
    logic [31:0] c_oe, c_dq, c_kn;

    sdram_resp #(.ROW_BITS(4), .COL_BITS(4), .T_RCD(T_RCD)) dut (
        .tb_clk(tb_clk), .tb_rst(tb_rst),
        .Cke(Cke), .Cs_n(Cs_n), .Ras_n(Ras_n), .Cas_n(Cas_n), .We_n(We_n),
        .Ba(Ba), .Addr(Addr), .Dqm(Dqm), .Dq_in(Dq_in),
        .Dq_out(Dq_out), .Dq_oe(Dq_oe),
        .err(err), .err_code(err_code), .cl(cl)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_flag(input int code);
        if (!m_err) begin
            m_err  = 1'b1;
            m_code = code;
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
        m_cl   = 0;
        m_err  = 1'b0;
        m_code = 0;
        exp_valid.delete();
        exp_data.delete();
        exp_known.delete();
        exp_oe.delete();
    endtask

    task automatic model_step();
        int b, base, key;
        bit any;
        logic [31:0] d, k, o;
        if (!(Cke && !Cs_n)) return;
        b   = int'(Ba);
        any = m_open[0] || m_open[1] || m_open[2] || m_open[3];
        case ({Ras_n, Cas_n, We_n})
            C_ACT: begin
                if (m_open[b]) model_flag(2);
                else begin
                    m_open[b] = 1'b1;
                    m_row[b]  = int'(Addr[3:0]);
                    m_act[b]  = cyc;
                end
            end
            C_PRE: begin
                if (Addr[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
                else m_open[b] = 1'b0;
            end
            C_REF: if (any) model_flag(6);
            C_MRS: begin
                if (any) model_flag(6);
                else if (Addr[2:0] == 3'd0 && Addr[6:4] == 3'd2) m_cl = 2;
                else if (Addr[2:0] == 3'd0 && Addr[6:4] == 3'd3) m_cl = 3;
                else model_flag(5);
            end
            C_RD, C_WR: begin
                if (m_cl == 0) model_flag(4);
                else if (!m_open[b]) model_flag(1);
                else if (cyc - m_act[b] < T_RCD) model_flag(3);
                else begin
                    base = (b * 256 + m_row[b] * 16 + int'(Addr[3:0])) * 4;
                    if (We_n == 1'b0) begin
                        if (exp_valid.exists(cyc - 1)) model_flag(7);
                        for (int i = 0; i < 4; i++)
                            if (!Dqm[i]) m_mem[base + i] = Dq_in[8*i +: 8];
                    end else begin
                        d = '0; k = '0; o = '0;
                        for (int i = 0; i < 4; i++) begin
                            key = base + i;
                            if (m_mem.exists(key)) begin
                                d[8*i +: 8] = m_mem[key];
                                k[8*i +: 8] = 8'hFF;
                            end
                            if (!Dqm[i]) o[8*i +: 8] = 8'hFF;
                        end
                        exp_valid[cyc + m_cl] = 1'b1;
                        exp_data[cyc + m_cl]  = d;
                        exp_known[cyc + m_cl] = k;
                        exp_oe[cyc + m_cl]    = o;
                    end
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge tb_clk) begin
        cyc++;
        if (!tb_rst) model_step();
    end

    // Every cycle out of reset, the DUT outputs must match what the model predicts.
    always @(negedge tb_clk) begin
        if (!tb_rst) begin
            c_oe = '0; c_dq = '0; c_kn = '0;
            if (exp_valid.exists(cyc)) begin
                c_oe = exp_oe[cyc];
                c_dq = exp_data[cyc];
                c_kn = exp_known[cyc] & c_oe;
            end
            checkOutput("model_dq_oe", Dq_oe, c_oe);
            if (c_kn != 0) checkOutput("model_dq_out", Dq_out & c_kn, c_dq & c_kn);
            checkOutput("model_err", {31'b0, err}, {31'b0, m_err});
            checkOutput("model_err_code", {29'b0, err_code}, 32'(m_code));
            checkOutput("model_cl", {30'b0, cl}, 32'(m_cl));
        end
    end

    task automatic applyStimulus(input logic [2:0] c, input logic [1:0] ba, input logic [10:0] a,
                                 input logic [3:0] m, input logic [31:0] d);
        Cke = 1'b1; Cs_n = 1'b0; {Ras_n, Cas_n, We_n} = c;
        Ba = ba; Addr = a; Dqm = m; Dq_in = d;
        @(negedge tb_clk);
        Cs_n = 1'b1; {Ras_n, Cas_n, We_n} = C_NOP;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic doReset();
        tb_rst = 1'b1;
        model_reset();
        #1;
        checkOutput("rst_dq_oe", Dq_oe, 32'h0);
        checkOutput("rst_dq_out", Dq_out, 32'h0);
        checkOutput("rst_err", {31'b0, err}, 32'h0);
        checkOutput("rst_err_code", {29'b0, err_code}, 32'h0);
        checkOutput("rst_cl", {30'b0, cl}, 32'h0);
        @(negedge tb_clk);
        tb_rst = 1'b0;
    endtask

    task automatic randomOp();
        int r, b;
        logic [2:0] c;
        logic [10:0] a;
        logic [3:0] m;
        r = $urandom_range(0, 99);
        b = $urandom_range(0, 3);
        a = 11'($urandom_range(0, 3));
        m = 4'($urandom_range(0, 15));
        c = C_NOP;
        if (r < 5) begin
            c = 3'($urandom_range(0, 7));
            a = 11'($urandom);
        end else if (!m_open[b]) c = (r < 70) ? C_ACT : C_PRE;
        else if (r < 45) c = C_RD;
        else if (r < 75) c = C_WR;
        else if (r < 85) begin
            c = C_PRE;
            if (r < 78) a[10] = 1'b1;
        end
        if (c == C_RD && m == 4'hF) m = 4'h0;
        applyStimulus(c, 2'(b), a, m, $urandom);
    endtask

    initial begin
        Cke = 1'b1; Cs_n = 1'b1; {Ras_n, Cas_n, We_n} = C_NOP;
        Ba = '0; Addr = '0; Dqm = '0; Dq_in = '0;
        model_reset();
        @(negedge tb_clk);
        doReset();

        $display("[TB] CL2 write then read");
        applyStimulus(C_MRS, 2'd0, 11'h020, 4'h0, 32'h0);
        checkOutput("cl_after_mode", {30'b0, cl}, 32'd2);
        applyStimulus(C_ACT, 2'd1, 11'd3, 4'h0, 32'h0);
        idle(1);
        applyStimulus(C_WR, 2'd1, 11'd5, 4'h0, 32'hDEADBEEF);
        applyStimulus(C_RD, 2'd1, 11'd5, 4'h0, 32'h0);
        checkOutput("cl2_oe_edge0", Dq_oe, 32'h0);
        idle(1);
        checkOutput("cl2_oe_edge1", Dq_oe, 32'h0);
        idle(1);
        checkOutput("cl2_oe_beat", Dq_oe, 32'hFFFFFFFF);
        checkOutput("cl2_dq_beat", Dq_out, 32'hDEADBEEF);
        checkOutput("cl2_err", {31'b0, err}, 32'h0);
        idle(1);
        checkOutput("cl2_oe_after", Dq_oe, 32'h0);

        $display("[TB] CL3 masked write and masked read");
        applyStimulus(C_PRE, 2'd0, 11'h400, 4'h0, 32'h0);
        applyStimulus(C_MRS, 2'd0, 11'h030, 4'h0, 32'h0);
        checkOutput("cl_after_mode3", {30'b0, cl}, 32'd3);
        applyStimulus(C_ACT, 2'd1, 11'd3, 4'h0, 32'h0);
        idle(1);
        // Bytes 0 and 2 written, bytes 1 and 3 keep the old data.
        applyStimulus(C_WR, 2'd1, 11'd5, 4'b1010, 32'h11223344);
        applyStimulus(C_RD, 2'd1, 11'd5, 4'h0, 32'h0);
        idle(2);
        checkOutput("cl3_oe_early", Dq_oe, 32'h0);
        idle(1);
        checkOutput("cl3_dq_merge", Dq_out, 32'hDE22BE44);
        applyStimulus(C_RD, 2'd1, 11'd5, 4'b1000, 32'h0);
        idle(3);
        checkOutput("cl3_oe_masked", Dq_oe, 32'h00FFFFFF);
        checkOutput("cl3_dq_masked", Dq_out & 32'h00FFFFFF, 32'h0022BE44);

        $display("[TB] read before mode load");
        doReset();
        applyStimulus(C_RD, 2'd0, 11'd0, 4'h0, 32'h0);
        checkOutput("nomode_err", {31'b0, err}, 32'd1);
        checkOutput("nomode_code", {29'b0, err_code}, 32'd4);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            checkOutput("nomode_oe", Dq_oe, 32'h0);
        end

        $display("[TB] tRCD violation and double activate");
        doReset();
        applyStimulus(C_MRS, 2'd0, 11'h020, 4'h0, 32'h0);
        applyStimulus(C_ACT, 2'd0, 11'd0, 4'h0, 32'h0);
        applyStimulus(C_RD, 2'd0, 11'd0, 4'h0, 32'h0);
        checkOutput("trcd_code", {29'b0, err_code}, 32'd3);
        applyStimulus(C_ACT, 2'd1, 11'd0, 4'h0, 32'h0);
        applyStimulus(C_ACT, 2'd1, 11'd0, 4'h0, 32'h0);
        checkOutput("first_code_held", {29'b0, err_code}, 32'd3);
        doReset();
        applyStimulus(C_ACT, 2'd2, 11'd1, 4'h0, 32'h0);
        applyStimulus(C_ACT, 2'd2, 11'd1, 4'h0, 32'h0);
        checkOutput("dbl_act_code", {29'b0, err_code}, 32'd2);

        $display("[TB] back-to-back reads and bus contention");
        doReset();
        applyStimulus(C_MRS, 2'd0, 11'h020, 4'h0, 32'h0);
        applyStimulus(C_ACT, 2'd0, 11'd1, 4'h0, 32'h0);
        idle(1);
        for (int i = 0; i < 4; i++) applyStimulus(C_WR, 2'd0, 11'(i), 4'h0, 32'hA0000000 + 32'(i));
        applyStimulus(C_RD, 2'd0, 11'd0, 4'h0, 32'h0);
        applyStimulus(C_RD, 2'd0, 11'd1, 4'h0, 32'h0);
        applyStimulus(C_RD, 2'd0, 11'd2, 4'h0, 32'h0);
        checkOutput("b2b_dq0", Dq_out, 32'hA0000000);
        applyStimulus(C_RD, 2'd0, 11'd3, 4'h0, 32'h0);
        checkOutput("b2b_dq1", Dq_out, 32'hA0000001);
        applyStimulus(C_WR, 2'd0, 11'd8, 4'h0, 32'h55555555);
        checkOutput("b2b_dq2", Dq_out, 32'hA0000002);
        checkOutput("contention_code", {29'b0, err_code}, 32'd7);
        idle(1);
        checkOutput("b2b_dq3", Dq_out, 32'hA0000003);
        checkOutput("b2b_oe3", Dq_oe, 32'hFFFFFFFF);
        idle(1);
        checkOutput("b2b_oe_end", Dq_oe, 32'h0);

        $display("[TB] reset during a pending read");
        doReset();
        applyStimulus(C_MRS, 2'd0, 11'h020, 4'h0, 32'h0);
        applyStimulus(C_ACT, 2'd0, 11'd1, 4'h0, 32'h0);
        idle(1);
        applyStimulus(C_RD, 2'd0, 11'd0, 4'h0, 32'h0);
        tb_rst = 1'b1;
        model_reset();
        #1;
        checkOutput("midrst_oe", Dq_oe, 32'h0);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            checkOutput("midrst_oe_hold", Dq_oe, 32'h0);
        end
        tb_rst = 1'b0;
        idle(2);
        checkOutput("midrst_no_beat", Dq_oe, 32'h0);
        checkOutput("midrst_cl", {30'b0, cl}, 32'h0);
        checkOutput("midrst_err", {31'b0, err}, 32'h0);
        applyStimulus(C_MRS, 2'd0, 11'h020, 4'h0, 32'h0);
        applyStimulus(C_ACT, 2'd0, 11'd1, 4'h0, 32'h0);
        idle(1);
        applyStimulus(C_RD, 2'd0, 11'd2, 4'h0, 32'h0);
        idle(2);
        checkOutput("beat_before_rst", Dq_oe, 32'hFFFFFFFF);
        tb_rst = 1'b1;
        model_reset();
        #1;
        checkOutput("async_rst_oe", Dq_oe, 32'h0);
        checkOutput("async_rst_dq", Dq_out, 32'h0);
        @(negedge tb_clk);
        tb_rst = 1'b0;

        $display("[TB] randomized command streams");
        for (int ep = 0; ep < 6; ep++) begin
            doReset();
            applyStimulus(C_MRS, 2'd0, ($urandom_range(0, 1) == 0) ? 11'h020 : 11'h030, 4'h0, 32'h0);
            for (int n = 0; n < 300; n++) randomOp();
            idle(4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
